// File: rtl/ft245_pkg.sv
// ============================================================================
// Module : ft245_pkg
// Brief  : Shared types and helpers for the FT245 synchronous FIFO PHY:
//          bus FSM state encoding, byte width, burst-counter width function.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package ft245_pkg;

  localparam int BYTE_W = 8;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_RX_OE    = 3'd1,
    ST_RX_READ  = 3'd2,
    ST_RX_END   = 3'd3,
    ST_TX_WRITE = 3'd4,
    ST_TURN     = 3'd5
  } ft245_state_t;

  // Width of a burst counter able to hold 0 .. burst_max-1.
  function automatic int burst_cnt_w(input int burst_max);
    return (burst_max > 2) ? $clog2(burst_max) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/ft245_tx_hold.sv
// ============================================================================
// Module : ft245_tx_hold
// Brief  : One-entry transmit holding register between the tx byte stream
//          and the FT245 write strobe. A byte leaves only when the FTDI
//          accepts it, so a txe_n stall keeps it for retry.
// Ports  : ftdi_clk, rst          clock / synchronous active-high reset
//          i_tx_data, i_tx_valid  incoming byte stream
//          o_tx_ready             byte taken this cycle when valid & ready
//          i_accept               FTDI took the held byte at this edge
//          o_full                 holding register occupied
//          o_full_nxt, o_byte_nxt contents after the coming edge
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module ft245_tx_hold
  import ft245_pkg::*;
(
  input  logic              ftdi_clk,
  input  logic              rst,
  input  logic [BYTE_W-1:0] i_tx_data,
  input  logic              i_tx_valid,
  output logic              o_tx_ready,
  input  logic              i_accept,
  output logic              o_full,
  output logic              o_full_nxt,
  output logic [BYTE_W-1:0] o_byte_nxt
);

  logic              r_full;
  logic [BYTE_W-1:0] r_byte;
  logic              w_accept;
  logic              w_load;

  assign w_accept   = i_accept & r_full;
  // A byte being accepted this edge frees the slot for a new one in the same cycle.
  assign o_tx_ready = ~rst & (~r_full | w_accept);
  assign w_load     = i_tx_valid & o_tx_ready;
  assign o_full     = r_full;

  always_comb begin
    o_full_nxt = r_full;
    o_byte_nxt = r_byte;
    if (w_load) begin
      o_full_nxt = 1'b1;
      o_byte_nxt = i_tx_data;
    end else if (w_accept) begin
      o_full_nxt = 1'b0;
    end
  end

  always_ff @(posedge ftdi_clk) begin
    if (rst) begin
      r_full <= 1'b0;
      r_byte <= '0;
    end else begin
      r_full <= o_full_nxt;
      r_byte <= o_byte_nxt;
    end
  end

endmodule

`default_nettype wire

// File: rtl/ft245_sync_phy.sv
// ============================================================================
// Module : ft245_sync_phy
// Brief  : FPGA-side PHY for the FT245 synchronous FIFO bus. Arbitrates
//          between RX bursts (priority) and TX bursts, drives oe_n/rd_n/wr_n
//          and the data bus, and converts to/from byte streams.
// Ports  : ftdi_clk, rst                  60 MHz FTDI clock / sync reset
//          ftdi_data_i/_o/_oe             tri-state data bus pad signals
//          ftdi_rde_n, ftdi_txe_n         FTDI RXF# / TXE# status
//          ftdi_oe_n/rd_n/wr_n/siwu       FTDI control strobes (registered)
//          rx_data, rx_valid, rx_afull    received byte stream
//          tx_data, tx_valid, tx_ready    transmit byte stream
// Config : FT245_SIWU_EN  enables the send-immediate idle timer; when left
//          undefined ftdi_siwu is tied high.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module ft245_sync_phy
  import ft245_pkg::*;
#(
  parameter int RX_BURST_MAX = 512,
  parameter int TX_BURST_MAX = 512,
  parameter int SIWU_IDLE    = 16
) (
  input  logic              ftdi_clk,
  input  logic              rst,
  input  logic [BYTE_W-1:0] ftdi_data_i,
  output logic [BYTE_W-1:0] ftdi_data_o,
  output logic              ftdi_data_oe,
  input  logic              ftdi_rde_n,
  input  logic              ftdi_txe_n,
  output logic              ftdi_oe_n,
  output logic              ftdi_rd_n,
  output logic              ftdi_wr_n,
  output logic              ftdi_siwu,
  output logic [BYTE_W-1:0] rx_data,
  output logic              rx_valid,
  input  logic              rx_afull,
  input  logic [BYTE_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready
);

  localparam int RX_CNT_W = burst_cnt_w(RX_BURST_MAX);
  localparam int TX_CNT_W = burst_cnt_w(TX_BURST_MAX);
  localparam logic [RX_CNT_W-1:0] c_rx_last = RX_CNT_W'(RX_BURST_MAX - 1);
  localparam logic [TX_CNT_W-1:0] c_tx_last = TX_CNT_W'(TX_BURST_MAX - 1);

  ft245_state_t      r_state, w_state_nxt;
  logic              r_oe_n, r_rd_n, r_wr_n, r_data_oe, r_rx_valid;
  logic [BYTE_W-1:0] r_data_o, r_rx_data;
  logic [RX_CNT_W-1:0] r_rx_cnt, w_rx_cnt_nxt;
  logic [TX_CNT_W-1:0] r_tx_cnt, w_tx_cnt_nxt;
  logic              w_oe_n_nxt, w_rd_n_nxt, w_wr_n_nxt, w_data_oe_nxt, w_rx_valid_nxt;
  logic [BYTE_W-1:0] w_data_o_nxt, w_rx_data_nxt;

  logic              w_tx_accept, w_hold_full, w_hold_full_nxt;
  logic [BYTE_W-1:0] w_hold_byte_nxt;
  logic              w_rx_go, w_tx_go, w_rx_exit, w_tx_exit;

  // The FTDI latches the bus byte on any edge where wr_n and txe_n are both low.
  assign w_tx_accept = ~r_wr_n & ~ftdi_txe_n;

  ft245_tx_hold u_tx_hold (
    .ftdi_clk   (ftdi_clk),
    .rst        (rst),
    .i_tx_data  (tx_data),
    .i_tx_valid (tx_valid),
    .o_tx_ready (tx_ready),
    .i_accept   (w_tx_accept),
    .o_full     (w_hold_full),
    .o_full_nxt (w_hold_full_nxt),
    .o_byte_nxt (w_hold_byte_nxt)
  );

  assign w_rx_go   = ~ftdi_rde_n & ~rx_afull;
  assign w_tx_go   = w_hold_full & ~ftdi_txe_n;
  assign w_rx_exit = ftdi_rde_n | rx_afull | (r_rx_cnt == c_rx_last);
  // Leave the write burst as soon as nothing valid will sit on the bus next
  // cycle; after 8 bytes a waiting RX burst pre-empts the transmitter.
  assign w_tx_exit = ~w_hold_full_nxt | ftdi_txe_n | (r_tx_cnt == c_tx_last) |
                     (~ftdi_rde_n & (32'(r_tx_cnt) >= 32'd8));

  // State and pin registers
  always_ff @(posedge ftdi_clk) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_oe_n     <= 1'b1;
      r_rd_n     <= 1'b1;
      r_wr_n     <= 1'b1;
      r_data_oe  <= 1'b0;
      r_data_o   <= '0;
      r_rx_data  <= '0;
      r_rx_valid <= 1'b0;
      r_rx_cnt   <= '0;
      r_tx_cnt   <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_oe_n     <= w_oe_n_nxt;
      r_rd_n     <= w_rd_n_nxt;
      r_wr_n     <= w_wr_n_nxt;
      r_data_oe  <= w_data_oe_nxt;
      r_data_o   <= w_data_o_nxt;
      r_rx_data  <= w_rx_data_nxt;
      r_rx_valid <= w_rx_valid_nxt;
      r_rx_cnt   <= w_rx_cnt_nxt;
      r_tx_cnt   <= w_tx_cnt_nxt;
    end
  end

  // Next state
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      ST_IDLE: begin
        if (w_rx_go)      w_state_nxt = ST_RX_OE;
        else if (w_tx_go) w_state_nxt = ST_TX_WRITE;
      end
      ST_RX_OE:    w_state_nxt = ST_RX_READ;
      ST_RX_READ:  if (w_rx_exit) w_state_nxt = ST_RX_END;
      ST_RX_END:   w_state_nxt = ST_TURN;
      ST_TX_WRITE: if (w_tx_exit) w_state_nxt = ST_TURN;
      ST_TURN:     w_state_nxt = ST_IDLE;
      default:     w_state_nxt = ST_IDLE;
    endcase
  end

  // Next values of the registered pins, stream outputs and counters
  always_comb begin
    w_oe_n_nxt     = r_oe_n;
    w_rd_n_nxt     = r_rd_n;
    w_wr_n_nxt     = r_wr_n;
    w_data_oe_nxt  = r_data_oe;
    w_data_o_nxt   = r_data_o;
    w_rx_data_nxt  = r_rx_data;
    w_rx_valid_nxt = 1'b0;
    w_rx_cnt_nxt   = r_rx_cnt;
    w_tx_cnt_nxt   = r_tx_cnt;
    unique case (r_state)
      ST_IDLE: begin
        if (w_rx_go) begin
          w_oe_n_nxt   = 1'b0;
          w_rx_cnt_nxt = '0;
        end else if (w_tx_go) begin
          w_data_oe_nxt = 1'b1;
          w_tx_cnt_nxt  = '0;
        end
      end
      ST_RX_OE: w_rd_n_nxt = 1'b0;
      ST_RX_READ: begin
        // The byte on the exit edge is still captured; the sink's afull
        // threshold leaves room for it.
        if (~r_rd_n & ~ftdi_rde_n) begin
          w_rx_data_nxt  = ftdi_data_i;
          w_rx_valid_nxt = 1'b1;
          if (r_rx_cnt != '1) w_rx_cnt_nxt = r_rx_cnt + 1'b1;
        end
        if (w_rx_exit) w_rd_n_nxt = 1'b1;
      end
      ST_RX_END: w_oe_n_nxt = 1'b1;
      ST_TX_WRITE: begin
        if (w_tx_accept && (r_tx_cnt != '1)) w_tx_cnt_nxt = r_tx_cnt + 1'b1;
        if (w_tx_exit) begin
          w_wr_n_nxt    = 1'b1;
          w_data_oe_nxt = 1'b0;
        end else begin
          // Present whatever the holding register will contain after this
          // edge, so bus data always matches the byte still awaiting acceptance.
          w_wr_n_nxt   = 1'b0;
          w_data_o_nxt = w_hold_byte_nxt;
        end
      end
      default: ;
    endcase
  end

  assign ftdi_oe_n    = r_oe_n;
  assign ftdi_rd_n    = r_rd_n;
  assign ftdi_wr_n    = r_wr_n;
  assign ftdi_data_oe = r_data_oe;
  assign ftdi_data_o  = r_data_o;
  assign rx_data      = r_rx_data;
  assign rx_valid     = r_rx_valid;

`ifdef FT245_SIWU_EN
  localparam int SIWU_W = $clog2(SIWU_IDLE + 1);
  localparam logic [SIWU_W-1:0] c_siwu_last = SIWU_W'(SIWU_IDLE - 1);

  logic [SIWU_W-1:0] r_siwu_cnt;
  logic              r_siwu_armed;
  logic              r_siwu_n;

  // Armed by each accepted byte, restarted by any pending tx byte, and
  // fires a single low pulse once the stream has been idle long enough.
  always_ff @(posedge ftdi_clk) begin
    if (rst) begin
      r_siwu_cnt   <= '0;
      r_siwu_armed <= 1'b0;
      r_siwu_n     <= 1'b1;
    end else begin
      r_siwu_n <= 1'b1;
      if (w_tx_accept) begin
        r_siwu_armed <= 1'b1;
        r_siwu_cnt   <= '0;
      end else if (tx_valid) begin
        r_siwu_cnt <= '0;
      end else if (r_siwu_armed) begin
        if (r_siwu_cnt == c_siwu_last) begin
          r_siwu_n     <= 1'b0;
          r_siwu_armed <= 1'b0;
          r_siwu_cnt   <= '0;
        end else begin
          r_siwu_cnt <= r_siwu_cnt + 1'b1;
        end
      end
    end
  end

  assign ftdi_siwu = r_siwu_n;
`else
  assign ftdi_siwu = 1'b1;
`endif

endmodule

`default_nettype wire

// File: tb/tb_ft245_sync_phy.sv
// ============================================================================
// Module : tb_ft245_sync_phy
// Brief  : Self-checking bench for ft245_sync_phy with an FT245 bus model,
//          byte-stream source/sink and end-to-end stream comparison.
// Rev    : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_ft245_sync_phy;

  logic       ftdi_clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] ftdi_data_i = 8'h00;
  logic [7:0] ftdi_data_o;
  logic       ftdi_data_oe;
  logic       ftdi_rde_n = 1'b1;
  logic       ftdi_txe_n = 1'b1;
  logic       ftdi_oe_n, ftdi_rd_n, ftdi_wr_n, ftdi_siwu;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_afull = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready;

  always #5 ftdi_clk = ~ftdi_clk;

  ft245_sync_phy dut (
    .ftdi_clk     (ftdi_clk),
    .rst          (rst),
    .ftdi_data_i  (ftdi_data_i),
    .ftdi_data_o  (ftdi_data_o),
    .ftdi_data_oe (ftdi_data_oe),
    .ftdi_rde_n   (ftdi_rde_n),
    .ftdi_txe_n   (ftdi_txe_n),
    .ftdi_oe_n    (ftdi_oe_n),
    .ftdi_rd_n    (ftdi_rd_n),
    .ftdi_wr_n    (ftdi_wr_n),
    .ftdi_siwu    (ftdi_siwu),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .rx_afull     (rx_afull),
    .tx_data      (tx_data),
    .tx_valid     (tx_valid),
    .tx_ready     (tx_ready)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference streams: what the FTDI holds / receives and what the fabric sends / sees.
  logic [7:0] ftdi_rxq[$];
  logic [7:0] ftdi_txq[$];
  logic [7:0] rx_got[$];
  logic [7:0] rx_exp[$];
  logic [7:0] tx_src[$];
  logic [7:0] tx_exp[$];
  bit txe_block = 1'b0;
  bit tx_en     = 1'b1;
  int n_conflict = 0;
  int n_siwu_low = 0;
  logic prev_oe_n = 1'b1;

  // FTDI chip + stream source/sink. Mid-cycle sampling sees exactly what the
  // next rising edge acts on; new input values appear 1 ns after that edge.
  always @(negedge ftdi_clk) begin : bus_model
    bit rd_fire, wr_fire, tx_fire;
    logic [7:0] wbyte;
    if (rx_valid) rx_got.push_back(rx_data);
    if (ftdi_data_oe && (!ftdi_oe_n || !prev_oe_n)) n_conflict++;
    prev_oe_n = ftdi_oe_n;
    if (!ftdi_siwu) n_siwu_low++;
    rd_fire = !ftdi_rd_n && !ftdi_rde_n;
    wr_fire = !ftdi_wr_n && !ftdi_txe_n;
    wbyte   = ftdi_data_o;
    tx_fire = tx_valid && tx_ready;
    @(posedge ftdi_clk);
    #1;
    if (rd_fire && ftdi_rxq.size() > 0) ftdi_rxq.delete(0);
    if (wr_fire) ftdi_txq.push_back(wbyte);
    if (tx_fire && tx_src.size() > 0) tx_src.delete(0);
    ftdi_rde_n  = (ftdi_rxq.size() == 0);
    ftdi_data_i = (!ftdi_oe_n && ftdi_rxq.size() > 0) ? ftdi_rxq[0] : 8'h00;
    ftdi_txe_n  = txe_block;
    tx_valid    = tx_en && (tx_src.size() > 0);
    tx_data     = tx_valid ? tx_src[0] : 8'h00;
  end

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge ftdi_clk);
      #2;
    end
  endtask

  task automatic push_rx(input logic [7:0] b);
    ftdi_rxq.push_back(b);
    rx_exp.push_back(b);
  endtask

  task automatic push_tx(input logic [7:0] b);
    tx_src.push_back(b);
    tx_exp.push_back(b);
  endtask

  task automatic wait_done(input int budget);
    int c;
    c = 0;
    while ((rx_got.size() < rx_exp.size() || ftdi_txq.size() < tx_exp.size()) && c < budget) begin
      step();
      c++;
    end
    step(4);
  endtask

  task automatic check_streams(input string tag);
    chk({tag, "_rx_len"}, rx_got.size(), rx_exp.size());
    for (int i = 0; i < rx_exp.size(); i++)
      chk({tag, "_rx_byte"}, (i < rx_got.size()) ? 32'(rx_got[i]) : 32'hFFFF_FFFF, 32'(rx_exp[i]));
    chk({tag, "_tx_len"}, ftdi_txq.size(), tx_exp.size());
    for (int i = 0; i < tx_exp.size(); i++)
      chk({tag, "_tx_byte"}, (i < ftdi_txq.size()) ? 32'(ftdi_txq[i]) : 32'hFFFF_FFFF, 32'(tx_exp[i]));
    rx_got.delete(); rx_exp.delete(); ftdi_txq.delete(); tx_exp.delete();
  endtask

  initial begin : main
    int t_oe, t_rd, t_rdh, t_oeh, t_wr, n0, n_snap, c;
    logic [7:0] b;
    logic [7:0] seq4[4];
    seq4[0] = 8'hCD; seq4[1] = 8'h01; seq4[2] = 8'h00; seq4[3] = 8'h00;

    // ---- reset state
    rst = 1'b1;
    step(3);
    chk("rst_oe_n", ftdi_oe_n, 1);
    chk("rst_rd_n", ftdi_rd_n, 1);
    chk("rst_wr_n", ftdi_wr_n, 1);
    chk("rst_siwu", ftdi_siwu, 1);
    chk("rst_data_oe", ftdi_data_oe, 0);
    chk("rst_data_o", ftdi_data_o, 0);
    chk("rst_rx_valid", rx_valid, 0);
    chk("rst_rx_data", rx_data, 0);
    chk("rst_tx_ready", tx_ready, 0);
    rst = 1'b0;
    step(3);

    // ---- RX burst of 4 bytes: oe_n, then rd_n a cycle later; oe_n released after rd_n
    for (int i = 0; i < 4; i++) push_rx(seq4[i]);
    t_oe = -1; t_rd = -1; t_rdh = -1; t_oeh = -1;
    for (int k = 0; k < 30; k++) begin
      step();
      if (t_oe < 0 && !ftdi_oe_n) t_oe = k;
      if (t_oe >= 0 && t_rd < 0 && !ftdi_rd_n) t_rd = k;
      if (t_rd >= 0 && t_rdh < 0 && ftdi_rd_n) t_rdh = k;
      if (t_rdh >= 0 && t_oeh < 0 && ftdi_oe_n) t_oeh = k;
    end
    chk("rx4_oe_seen", 32'(t_oe >= 0), 1);
    chk("rx4_rd_after_oe", t_rd - t_oe, 1);
    chk("rx4_oe_rel_after_rd", t_oeh - t_rdh, 1);
    check_streams("rx4");

    // ---- rx_afull mid-burst of 10
    for (int i = 0; i < 10; i++) push_rx(8'($urandom));
    c = 0;
    while (rx_got.size() < 3 && c < 50) begin step(); c++; end
    chk("afull_burst_started", 32'(rx_got.size() >= 3), 1);
    rx_afull = 1'b1;
    step();
    chk("afull_rd_n_high", ftdi_rd_n, 1);
    n0 = rx_got.size();
    step(8);
    chk("afull_extra_le1", 32'((rx_got.size() - n0) <= 1), 1);
    rx_afull = 1'b0;
    wait_done(200);
    check_streams("afull");

    // ---- TX 8 bytes with a txe_n stall after the third byte
    for (int i = 0; i < 8; i++) push_tx(8'(i));
    c = 0;
    while (ftdi_txq.size() < 3 && c < 50) begin step(); c++; end
    txe_block = 1'b1;
    step(2);
    txe_block = 1'b0;
    wait_done(200);
    check_streams("tx8");

    // ---- RX and TX pending together in IDLE: RX goes first
    step(4);
    for (int i = 0; i < 5; i++) begin
      push_rx(8'($urandom));
      push_tx(8'($urandom));
    end
    t_oe = 1000; t_wr = 1000;
    for (int k = 0; k < 60; k++) begin
      step();
      if (t_oe == 1000 && !ftdi_oe_n) t_oe = k;
      if (t_wr == 1000 && !ftdi_wr_n) t_wr = k;
    end
    chk("prio_rx_first", 32'(t_oe < t_wr), 1);
    wait_done(200);
    check_streams("prio");

    // ---- randomized traffic with txe_n stalls and afull back-pressure
    for (int it = 0; it < 6; it++) begin
      int nrx, ntx;
      nrx = $urandom_range(1, 24);
      ntx = $urandom_range(1, 24);
      for (int k = 0; k < nrx; k++) begin b = 8'($urandom); push_rx(b); end
      for (int k = 0; k < ntx; k++) begin b = 8'($urandom); push_tx(b); end
      c = 0;
      while ((rx_got.size() < rx_exp.size() || ftdi_txq.size() < tx_exp.size()) && c < 600) begin
        rx_afull  = ($urandom_range(0, 3) == 0);
        txe_block = ($urandom_range(0, 4) == 0);
        step();
        c++;
      end
      rx_afull = 1'b0;
      txe_block = 1'b0;
      wait_done(100);
      check_streams("rand");
    end

    // ---- reset in the middle of a write burst
    for (int i = 0; i < 6; i++) push_tx(8'(8'h40 + i));
    c = 0;
    while (ftdi_wr_n && c < 50) begin step(); c++; end
    chk("rst_tx_started", ftdi_wr_n, 0);
    rst = 1'b1;
    #1;
    chk("rst_mid_tx_ready", tx_ready, 0);
    step();
    chk("rst_mid_wr_n", ftdi_wr_n, 1);
    chk("rst_mid_rd_n", ftdi_rd_n, 1);
    chk("rst_mid_oe_n", ftdi_oe_n, 1);
    chk("rst_mid_data_oe", ftdi_data_oe, 0);
    chk("rst_mid_data_o", ftdi_data_o, 0);
    tx_en = 1'b0;
    step(2);
    rst = 1'b0;
    n_snap = ftdi_txq.size();
    step(10);
    chk("rst_hold_no_write", ftdi_txq.size(), n_snap);
    chk("rst_hold_empty_ready", tx_ready, 1);
    tx_src.delete(); tx_exp.delete(); ftdi_txq.delete();
    tx_en = 1'b1;

    // ---- send-immediate after an idle stretch
    step(40);
`ifdef FT245_SIWU_EN
    n_siwu_low = 0;
    push_tx(8'hA5);
    wait_done(50);
    step(40);
    chk("siwu_single_pulse", n_siwu_low, 1);
    check_streams("siwu");
`else
    push_tx(8'hA5);
    wait_done(50);
    step(40);
    chk("siwu_never_low", n_siwu_low, 0);
    check_streams("siwu");
`endif

    chk("bus_conflict", n_conflict, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
